branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, address fetched first after reset.
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  16  fetch address, equal to pc.
- imem_ack  in  1  fetch data valid, one-cycle pulse.
- imem_rdata  in  16  fetched instruction word.
- instr_valid  out  1  instruction offered to decode.
- instr_ready  in  1  decode accepts the instruction.
- instr_out  out  16  held instruction word.
- instr_pc  out  16  address of instr_out.
- br_valid  in  1  accepted instruction is a branch; sampled with instr_ready.
- br_type  in  4  `OP_JMP/`OP_BRZ/`OP_BRNZ/`OP_BRNS from defines.vh; sampled with instr_ready.
- br_offset  in  16  signed PC-relative offset; sampled with instr_ready.
- flag_we  in  1  write flags register.
- flag_in  in  4  new flags: [0]=Z, [1]=S, [3:2] reserved.
- flags  out  4  registered flags.
- pc  out  16  current program counter.
- br_taken  out  1  one-cycle pulse, branch taken.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states: IDLE, FETCH, OFFER, RESOLVE; one instruction in flight at a time, no speculation.
REQ-004 IDLE: lasts exactly one cycle after reset is released, then moves to FETCH.
REQ-005 FETCH: imem_req=1 and imem_addr=pc.
- On imem_ack, capture imem_rdata into instr_out and pc into instr_pc, then move to OFFER.
- imem_ack outside FETCH is ignored.
REQ-006 OFFER: instr_valid=1; instr_out and instr_pc stay stable until the handshake.
- Handshake = instr_valid & instr_ready.
- On handshake with br_valid=0: pc <= pc+1, next state FETCH.
- On handshake with br_valid=1: latch br_type and br_offset, next state RESOLVE.
REQ-007 RESOLVE: one cycle; taken condition:
- JMP: always.
- BRZ: Z=1.
- BRNZ: Z=0.
- BRNS: S=0.
- Any other br_type: not taken.
REQ-008 RESOLVE update: taken -> pc <= instr_pc + br_offset; not taken -> pc <= instr_pc + 1. Next state FETCH.
REQ-009 br_taken pulses for exactly the one RESOLVE cycle when the branch is taken.
REQ-010 Arithmetic: all address sums are 16-bit modulo 2^16; 16'hFFFF+1 wraps to 16'h0000; offset 16'hFFFF targets instr_pc-1.
REQ-011 Flags register:
- Loads flag_in on any cycle with flag_we=1, in every state.
- flags[3:2] are stored but never affect branching.
REQ-012 Branch-to-fetch latency: imem_req asserts on the cycle after RESOLVE.

Reset
REQ-013 rst=1 asynchronously forces:
- state=IDLE, pc=RESET_PC, flags=0.
- instr_out=0, instr_pc=0.
- imem_req=0, instr_valid=0, br_taken=0.
REQ-014 Reset mid-fetch or mid-offer discards the in-flight instruction; an imem_ack arriving after reset is ignored unless the FSM is in FETCH.

Configuration
REQ-015 Macro FLAG_FWD_EN:
- Defined: RESOLVE evaluates flag_in when flag_we=1 in that same cycle, otherwise the flags register.
- Undefined: RESOLVE evaluates only the flags register value held before that cycle's write.

Verification
REQ-016 Reset release, RESET_PC=16'h0010, ack after 2 cycles, non-branch accepted -> first imem_addr=16'h0010, then 16'h0011.
REQ-017 BRZ, flags=4'b0001, instr_pc=16'h0020, offset=16'h0005 -> br_taken pulse, next imem_addr=16'h0025.
REQ-018 BRNS, flags=4'b0010 -> not taken, next imem_addr=instr_pc+1; JMP at 16'hFFFE, offset 16'h0003 -> 16'h0001.
REQ-019 instr_ready held low for 5 cycles -> instr_valid stays high, instr_out/instr_pc unchanged, no imem_req.
REQ-020 BRZ, flags=0, flag_we=1 with flag_in=4'b0001 in the RESOLVE cycle -> taken with FLAG_FWD_EN, not taken without.
REQ-021 rst asserted during FETCH, then stray imem_ack -> outputs at reset values immediately, ack ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/branch_sequencer.sv
// Single-issue fetch/offer/resolve sequencer with PC-relative branches.
// Optional FLAG_FWD_EN forwards same-cycle flag writes into branch resolution.
`ifndef OP_JMP
`define OP_JMP  4'h1
`endif
`ifndef OP_BRZ
`define OP_BRZ  4'h2
`endif
`ifndef OP_BRNZ
`define OP_BRNZ 4'h3
`endif
`ifndef OP_BRNS
`define OP_BRNS 4'h4
`endif

module branch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  input  logic        br_valid,
  input  logic [3:0]  br_type,
  input  logic [15:0] br_offset,
  input  logic        flag_we,
  input  logic [3:0]  flag_in,
  output logic [3:0]  flags,
  output logic [15:0] pc,
  output logic        br_taken,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OFFER,
    RESOLVE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  br_type_q;
  logic [15:0] br_off_q;
  logic [3:0]  eval_flags;
  logic        taken;
  logic        hs;

`ifdef FLAG_FWD_EN
  assign eval_flags = flag_we ? flag_in : flags;
`else
  assign eval_flags = flags;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    br_taken    = 1'b0;
    busy        = 1'b1;
    taken       = 1'b0;
    hs          = 1'b0;
    case (br_type_q)
      `OP_JMP:  taken = 1'b1;
      `OP_BRZ:  taken = eval_flags[0];
      `OP_BRNZ: taken = ~eval_flags[0];
      `OP_BRNS: taken = ~eval_flags[1];
      default:  taken = 1'b0;
    endcase
    unique case (state)
      IDLE: begin
        busy       = 1'b0;
        next_state = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) next_state = OFFER;
      end
      OFFER: begin
        instr_valid = 1'b1;
        hs          = instr_ready;
        if (hs) next_state = br_valid ? RESOLVE : FETCH;
      end
      RESOLVE: begin
        br_taken   = taken;
        next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      instr_out <= 16'h0000;
      instr_pc  <= 16'h0000;
      br_type_q <= 4'h0;
      br_off_q  <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr_out <= imem_rdata;
            instr_pc  <= pc;
          end
        end
        OFFER: begin
          if (hs && br_valid) begin
            br_type_q <= br_type;
            br_off_q  <= br_offset;
          end else if (hs) begin
            pc <= pc + 16'd1;
          end
        end
        RESOLVE: begin
          pc <= taken ? instr_pc + br_off_q
                      : instr_pc + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Flags load in every state, independent of the sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          flags <= 4'h0;
    else if (flag_we) flags <= flag_in;
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer (RESET_PC = 16'h0010).
// Expected branch targets are hand-computed per vector.
`ifndef OP_JMP
`define OP_JMP  4'h1
`endif
`ifndef OP_BRZ
`define OP_BRZ  4'h2
`endif
`ifndef OP_BRNZ
`define OP_BRNZ 4'h3
`endif
`ifndef OP_BRNS
`define OP_BRNS 4'h4
`endif

module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        br_valid;
  logic [3:0]  br_type;
  logic [15:0] br_offset;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic [3:0]  flags;
  logic [15:0] pc;
  logic        br_taken;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic fwd_exp;

  always #5 clk = ~clk;

  branch_sequencer #(.RESET_PC(16'h0010)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .br_valid(br_valid), .br_type(br_type),
    .br_offset(br_offset), .flag_we(flag_we),
    .flag_in(flag_in), .flags(flags), .pc(pc),
    .br_taken(br_taken), .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    chk("req_wait", {15'd0, imem_req}, 16'd1);
  endtask

  task automatic do_fetch(input logic [15:0] a,
                          input logic [15:0] d);
    wait_req();
    chk("f_addr", imem_addr, a);
    imem_ack   = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack = 1'b0;
    chk("f_valid", {15'd0, instr_valid}, 16'd1);
    chk("f_ipc", instr_pc, a);
    chk("f_data", instr_out, d);
  endtask

  task automatic do_branch(input logic [3:0] t,
                           input logic [15:0] off,
                           input logic tk,
                           input logic [15:0] nxt);
    instr_ready = 1'b1;
    br_valid    = 1'b1;
    br_type     = t;
    br_offset   = off;
    tick();
    instr_ready = 1'b0;
    br_valid    = 1'b0;
    br_offset   = 16'h0;
    chk("b_taken", {15'd0, br_taken}, {15'd0, tk});
    tick();
    chk("b_req", {15'd0, imem_req}, 16'd1);
    chk("b_next", imem_addr, nxt);
    chk("b_pulse", {15'd0, br_taken}, 16'd0);
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1;
    flag_in = f;
    tick();
    flag_we = 1'b0;
    chk("flags", {12'd0, flags}, {12'd0, f});
  endtask

  initial begin
`ifdef FLAG_FWD_EN
    fwd_exp = 1'b1;
`else
    fwd_exp = 1'b0;
`endif
    rst = 1'b1;
    imem_ack = 0; imem_rdata = 0;
    instr_ready = 0; br_valid = 0;
    br_type = 0; br_offset = 0;
    flag_we = 0; flag_in = 0;
    tick(); tick();
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_pc", pc, 16'h0010);
    chk("rst_flags", {12'd0, flags}, 16'd0);
    chk("rst_iout", instr_out, 16'd0);
    chk("rst_ipc", instr_pc, 16'd0);
    rst = 1'b0;
    #1;
    chk("idle_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("first_req", {15'd0, imem_req}, 16'd1);
    chk("first_addr", imem_addr, 16'h0010);
    tick(); tick();
    chk("hold_req", {15'd0, imem_req}, 16'd1);
    do_fetch(16'h0010, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      imem_ack   = (i == 2);
      imem_rdata = 16'hBEEF;
      tick();
      chk("st_valid", {15'd0, instr_valid}, 16'd1);
      chk("st_iout", instr_out, 16'h1234);
      chk("st_ipc", instr_pc, 16'h0010);
      chk("st_noreq", {15'd0, imem_req}, 16'd0);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("seq_addr", imem_addr, 16'h0011);
    do_fetch(16'h0011, 16'hA001);
    do_branch(`OP_JMP, 16'h000F, 1'b1, 16'h0020);
    set_flags(4'b0001);
    do_fetch(16'h0020, 16'hA002);
    do_branch(`OP_BRZ, 16'h0005, 1'b1, 16'h0025);
    set_flags(4'b0010);
    do_fetch(16'h0025, 16'hA003);
    do_branch(`OP_BRNS, 16'h0100, 1'b0, 16'h0026);
    do_fetch(16'h0026, 16'hA004);
    do_branch(`OP_BRNZ, 16'hFFFF, 1'b1, 16'h0025);
    do_fetch(16'h0025, 16'hA005);
    do_branch(4'hF, 16'h0005, 1'b0, 16'h0026);
    set_flags(4'b1100);
    do_fetch(16'h0026, 16'hA006);
    do_branch(`OP_BRZ, 16'h0040, 1'b0, 16'h0027);
    do_fetch(16'h0027, 16'hA007);
    do_branch(`OP_JMP, 16'hFFD7, 1'b1, 16'hFFFE);
    do_fetch(16'hFFFE, 16'hA008);
    do_branch(`OP_JMP, 16'h0003, 1'b1, 16'h0001);
    set_flags(4'b0000);
    do_fetch(16'h0001, 16'hA009);
    instr_ready = 1'b1;
    br_valid    = 1'b1;
    br_type     = `OP_BRZ;
    br_offset   = 16'h0010;
    tick();
    instr_ready = 1'b0;
    br_valid    = 1'b0;
    flag_we     = 1'b1;
    flag_in     = 4'b0001;
    #1;
    chk("fwd_taken", {15'd0, br_taken}, {15'd0, fwd_exp});
    tick();
    flag_we = 1'b0;
    chk("fwd_flags", {12'd0, flags}, 16'd1);
    chk("fwd_next", imem_addr, fwd_exp ? 16'h0011 : 16'h0002);
    rst = 1'b1;
    #1;
    chk("ar_req", {15'd0, imem_req}, 16'd0);
    chk("ar_pc", pc, 16'h0010);
    chk("ar_flags", {12'd0, flags}, 16'd0);
    chk("ar_iout", instr_out, 16'd0);
    chk("ar_busy", {15'd0, busy}, 16'd0);
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    chk("rr_req", {15'd0, imem_req}, 16'd1);
    chk("rr_addr", imem_addr, 16'h0010);
    chk("rr_valid", {15'd0, instr_valid}, 16'd0);
    tick();
    chk("rr_still", {15'd0, instr_valid}, 16'd0);
    chk("rr_iout", instr_out, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
